// File: rtl/instruction_fetch.sv
// Instruction fetch stage: walks the PC through instruction memory, resolves
// unconditional jumps early, and restarts on execute-stage redirects.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_WORD   = 16'h0000,
  parameter logic [3:0]  JMP_OPCODE = 4'b1101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_id,
  input  logic        redirect_ex,
  input  logic [15:0] redirect_target_ex,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction_if,
  output logic [15:0] next_program_counter_if,
  output logic        branch_prediction_bp
);

  // state | meaning
  // BOOT  | one idle cycle after reset, no memory request
  // FETCH | requesting the word at pc
  // STALL | decode is full; pc and outputs held, no request
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic        is_jmp;

  assign pc_inc = pc + 16'd1;
  assign is_jmp = (imem_rdata[15:12] == JMP_OPCODE);

  // A stall seen in FETCH suppresses the request that same cycle, since the
  // returned word could not be accepted anyway.
  assign imem_req  = (state == FETCH) && !stall_id;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                   <= BOOT;
      pc                      <= RESET_PC;
      instruction_if          <= NOP_WORD;
      next_program_counter_if <= RESET_PC;
      branch_prediction_bp    <= 1'b0;
    end else begin
      branch_prediction_bp <= redirect_ex;
      if (redirect_ex) begin
        state          <= FETCH;
        pc             <= redirect_target_ex;
        instruction_if <= NOP_WORD;
      end else begin
        case (state)
          BOOT: state <= FETCH;
          FETCH: begin
            if (stall_id) begin
              state <= STALL;
            end else if (imem_ready) begin
              instruction_if          <= imem_rdata;
              next_program_counter_if <= pc_inc;
              pc <= is_jmp ? {pc[15:12], imem_rdata[11:0]} : pc_inc;
            end else begin
              instruction_if <= NOP_WORD;
            end
          end
          STALL: begin
            if (!stall_id) state <= FETCH;
          end
          default: state <= BOOT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_id;
  logic        redirect_ex;
  logic [15:0] redirect_target_ex;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] instruction_if;
  logic [15:0] next_program_counter_if;
  logic        branch_prediction_bp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .stall_id(stall_id),
    .redirect_ex(redirect_ex), .redirect_target_ex(redirect_target_ex),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instruction_if(instruction_if),
    .next_program_counter_if(next_program_counter_if),
    .branch_prediction_bp(branch_prediction_bp)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'h1234;
      16'h0001: mem_word = 16'h2345;
      16'h3010: mem_word = 16'hD0A5;
      16'hFFFF: mem_word = 16'h1000;
      default:  mem_word = {4'h7, a[11:0]};
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_id = 1'b0; redirect_ex = 1'b0;
    redirect_target_ex = 16'h0000; imem_ready = 1'b1;
    #3;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", imem_addr); end
    checks++; if (instruction_if !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", instruction_if); end
    checks++; if (next_program_counter_if !== 16'h0000) begin errors++; $display("FAIL reset_npc got %h want 0000", next_program_counter_if); end
    checks++; if (branch_prediction_bp !== 1'b0) begin errors++; $display("FAIL reset_bp got %b want 0", branch_prediction_bp); end
    step(); step();
  endtask

  task automatic test_basic_fetch();
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b want 0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL fetch0_req got %b/%h want 1/0000", imem_req, imem_addr); end
    step();
    checks++; if (instruction_if !== 16'h1234 || next_program_counter_if !== 16'h0001) begin errors++; $display("FAIL fetch0_out got %h/%h want 1234/0001", instruction_if, next_program_counter_if); end
    step();
    checks++; if (instruction_if !== 16'h2345 || next_program_counter_if !== 16'h0002) begin errors++; $display("FAIL fetch1_out got %h/%h want 2345/0002", instruction_if, next_program_counter_if); end
    step(); step(); step();
    checks++; if (instruction_if !== 16'h7004 || next_program_counter_if !== 16'h0005 || imem_addr !== 16'h0005) begin errors++; $display("FAIL fetch4_out got %h/%h/%h want 7004/0005/0005", instruction_if, next_program_counter_if, imem_addr); end
  endtask

  task automatic test_not_ready();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (instruction_if !== 16'h0000 || imem_addr !== 16'h0005 || next_program_counter_if !== 16'h0005) begin errors++; $display("FAIL bubble%0d got %h/%h/%h want 0000/0005/0005", i, instruction_if, imem_addr, next_program_counter_if); end
    end
    imem_ready = 1'b1;
    step();
    checks++; if (instruction_if !== 16'h7005 || next_program_counter_if !== 16'h0006) begin errors++; $display("FAIL after_bubble got %h/%h want 7005/0006", instruction_if, next_program_counter_if); end
  endtask

  task automatic test_stall();
    redirect_ex = 1'b1; redirect_target_ex = 16'h0000;
    step();
    redirect_ex = 1'b0;
    step();
    checks++; if (instruction_if !== 16'h1234 || next_program_counter_if !== 16'h0001) begin errors++; $display("FAIL stall_pre got %h/%h want 1234/0001", instruction_if, next_program_counter_if); end
    stall_id = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req%0d got %b want 0", i, imem_req); end
      step();
      checks++; if (instruction_if !== 16'h1234 || next_program_counter_if !== 16'h0001 || imem_addr !== 16'h0001) begin errors++; $display("FAIL stall_hold%0d got %h/%h/%h want 1234/0001/0001", i, instruction_if, next_program_counter_if, imem_addr); end
    end
    stall_id = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_exit_req got %b want 0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0001) begin errors++; $display("FAIL stall_resume got %b/%h want 1/0001", imem_req, imem_addr); end
    step();
    checks++; if (instruction_if !== 16'h2345 || next_program_counter_if !== 16'h0002) begin errors++; $display("FAIL stall_next got %h/%h want 2345/0002", instruction_if, next_program_counter_if); end
  endtask

  task automatic test_redirect();
    stall_id = 1'b1; redirect_ex = 1'b1; redirect_target_ex = 16'h0040;
    step();
    stall_id = 1'b0; redirect_ex = 1'b0;
    #1;
    checks++; if (instruction_if !== 16'h0000 || branch_prediction_bp !== 1'b1 || imem_addr !== 16'h0040 || imem_req !== 1'b1) begin errors++; $display("FAIL redir_stall got %h/%b/%h/%b want 0000/1/0040/1", instruction_if, branch_prediction_bp, imem_addr, imem_req); end
    step();
    checks++; if (branch_prediction_bp !== 1'b0 || instruction_if !== 16'h7040) begin errors++; $display("FAIL redir_after got %b/%h want 0/7040", branch_prediction_bp, instruction_if); end
    redirect_ex = 1'b1; redirect_target_ex = 16'h0100;
    step();
    redirect_target_ex = 16'h0200;
    step();
    redirect_ex = 1'b0;
    checks++; if (branch_prediction_bp !== 1'b1 || imem_addr !== 16'h0200 || instruction_if !== 16'h0000) begin errors++; $display("FAIL redir_b2b got %b/%h/%h want 1/0200/0000", branch_prediction_bp, imem_addr, instruction_if); end
    step();
    checks++; if (branch_prediction_bp !== 1'b0) begin errors++; $display("FAIL redir_b2b_clear got %b want 0", branch_prediction_bp); end
  endtask

  task automatic test_jump_wrap();
    redirect_ex = 1'b1; redirect_target_ex = 16'h3010;
    step();
    redirect_ex = 1'b0;
    step();
    checks++; if (instruction_if !== 16'hD0A5 || next_program_counter_if !== 16'h3011 || imem_addr !== 16'h30A5) begin errors++; $display("FAIL jump got %h/%h/%h want D0A5/3011/30A5", instruction_if, next_program_counter_if, imem_addr); end
    redirect_ex = 1'b1; redirect_target_ex = 16'hFFFF;
    step();
    redirect_ex = 1'b0;
    step();
    checks++; if (instruction_if !== 16'h1000 || next_program_counter_if !== 16'h0000 || imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap got %h/%h/%h want 1000/0000/0000", instruction_if, next_program_counter_if, imem_addr); end
  endtask

  task automatic test_reset_in_stall();
    redirect_ex = 1'b1; redirect_target_ex = 16'h0077;
    step();
    redirect_ex = 1'b0; stall_id = 1'b1;
    step();
    checks++; if (imem_addr !== 16'h0077 || imem_req !== 1'b0) begin errors++; $display("FAIL pre_reset got %h/%b want 0077/0", imem_addr, imem_req); end
    reset = 1'b1;
    #1;
    checks++; if (imem_addr !== 16'h0000 || instruction_if !== 16'h0000 || next_program_counter_if !== 16'h0000 || branch_prediction_bp !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL async_reset got %h/%h/%h/%b/%b want 0000/0000/0000/0/0", imem_addr, instruction_if, next_program_counter_if, branch_prediction_bp, imem_req); end
    step();
    reset = 1'b0; stall_id = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reboot_req got %b want 0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL refetch got %b/%h want 1/0000", imem_req, imem_addr); end
    step();
    checks++; if (instruction_if !== 16'h1234 || next_program_counter_if !== 16'h0001) begin errors++; $display("FAIL refetch_out got %h/%h want 1234/0001", instruction_if, next_program_counter_if); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_not_ready();
    test_stall();
    test_redirect();
    test_jump_wrap();
    test_reset_in_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_WORD, default 16'h0000, giving the bubble instruction (opcode 4'b0000).
REQ-003 The block SHALL have parameter JMP_OPCODE, default 4'b1101, giving the unconditional-jump opcode resolved early in fetch.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall_id  input  1  decode cannot accept a new instruction this cycle.
REQ-007 redirect_ex  input  1  execute resolved a taken branch; fetch must restart.
REQ-008 redirect_target_ex  input  16  restart address, valid when redirect_ex=1.
REQ-009 imem_req  output  1  instruction memory read request.
REQ-010 imem_addr  output  16  read address, equal to the PC register.
REQ-011 imem_ready  input  1  imem_rdata valid for imem_addr this cycle.
REQ-012 imem_rdata  input  16  instruction word.
REQ-013 instruction_if  output  16  registered instruction to decode.
REQ-014 next_program_counter_if  output  16  registered address of instruction_if plus 1.
REQ-015 branch_prediction_bp  output  1  registered squash flag; decode replaces its opcode with NOP while high.

Function
REQ-016 The block SHALL implement FSM states BOOT, FETCH, STALL; BOOT is entered on reset.
REQ-017 BOOT SHALL last exactly one cycle with imem_req=0, then go to FETCH.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, both combinational from state and pc.
REQ-019 In FETCH with imem_ready=1 and no stall/redirect: instruction_if<=imem_rdata, next_program_counter_if<=pc+1, pc<=pc+1.
REQ-020 In FETCH with imem_ready=1 and imem_rdata[15:12]==JMP_OPCODE: pc<={pc[15:12], imem_rdata[11:0]} instead of pc+1; instruction_if and next_program_counter_if as REQ-019.
REQ-021 In FETCH with imem_ready=0: instruction_if<=NOP_WORD, pc unchanged, next_program_counter_if unchanged.
REQ-022 stall_id=1 (no redirect) in FETCH or STALL: state<=STALL, imem_req=0, pc, instruction_if, next_program_counter_if held.
REQ-023 STALL with stall_id=0 SHALL return to FETCH next cycle.
REQ-024 redirect_ex=1 SHALL have highest priority in every non-reset state: pc<=redirect_target_ex, instruction_if<=NOP_WORD, state<=FETCH, branch_prediction_bp<=1; imem_rdata that cycle discarded.
REQ-025 branch_prediction_bp SHALL be 1 only in the cycle after a redirect_ex cycle, 0 otherwise; back-to-back redirects keep it 1.
REQ-026 pc arithmetic SHALL be 16-bit modulo; 16'hFFFF+1 wraps to 16'h0000, and next_program_counter_if wraps likewise.
REQ-027 redirect_ex together with stall_id SHALL perform the redirect and enter FETCH, not STALL.
REQ-028 imem_rdata SHALL be ignored whenever imem_req=0.

Reset
REQ-029 While reset=1: state=BOOT, pc=RESET_PC, instruction_if=NOP_WORD, next_program_counter_if=RESET_PC, branch_prediction_bp=0, imem_req=0, independent of clk.
REQ-030 Reset asserted mid-fetch or mid-stall SHALL discard all in-flight state; first request after release is RESET_PC following one BOOT cycle.

Verification
REQ-031 Reset release, imem_ready=1, memory returns 16'h1234 at 0, 16'h2345 at 1 -> cycle 2 imem_addr=0; instruction_if=16'h1234/next PC=1, then 16'h2345/2.
REQ-032 imem_ready=0 for 3 cycles at pc=5 -> three NOP bubbles, imem_addr stays 5, then word at 5 with next PC=6.
REQ-033 stall_id=1 for 2 cycles while instruction_if=16'h1234 -> imem_req=0, outputs held 2 cycles, fetch resumes at same pc.
REQ-034 redirect_ex=1, target 16'h0040, with stall_id=1 same cycle -> next cycle instruction_if=NOP, branch_prediction_bp=1, imem_addr=16'h0040, state FETCH.
REQ-035 pc=16'h3010 returns 16'hD0A5 -> pc becomes 16'h30A5; pc=16'hFFFF returns 16'h1000 -> next PC 16'h0000.
REQ-036 reset pulsed during STALL with pc=16'h0077 -> pc=RESET_PC, outputs at reset values, BOOT then fetch from 16'h0000.
